// File: rtl/bellman_relax.sv
// ---------------------------------------------------------------------------------------------
// bellman_relax
//   Bellman-Ford relaxation stage. On an accepted start it writes every vertmat word to
//   {pred=self, dist=0}, then sweeps all (i,j) pairs of adjmat for up to N_NODES-1 passes,
//   writing {i, dist_i+w} into vertex j whenever that is strictly smaller than dist_j.
//   A pass with no update ends the run early. relax_done is a level held in DONE.
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   relax_start         start pulse, accepted only in IDLE or DONE
//   adjmat_row_addr     edge source index i          (adjmat read, 1-cycle latency)
//   adjmat_col_addr     edge destination index j
//   adjmat_q            signed edge weight, 0 = no edge
//   vertmat_addr_a/q_a  read port for source vertex i
//   vertmat_addr_b/q_b  read/write port for destination vertex j
//   vertmat_wren_b      port B write enable
//   vertmat_data_b      port B write data {pred, dist}
//   relax_busy          run in progress
//   relax_done          run finished (level)
//   relax_passes        passes executed in the last run
// ---------------------------------------------------------------------------------------------
module bellman_relax #(
    parameter int unsigned N_NODES  = 8,
    parameter int unsigned IDX_W    = 3,
    parameter int unsigned WEIGHT_W = 16,
    parameter int unsigned VERT_W   = IDX_W + WEIGHT_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                relax_start,
    output logic [IDX_W-1:0]    adjmat_row_addr,
    output logic [IDX_W-1:0]    adjmat_col_addr,
    input  logic [WEIGHT_W-1:0] adjmat_q,
    output logic [IDX_W-1:0]    vertmat_addr_a,
    input  logic [VERT_W-1:0]   vertmat_q_a,
    output logic [IDX_W-1:0]    vertmat_addr_b,
    input  logic [VERT_W-1:0]   vertmat_q_b,
    output logic                vertmat_wren_b,
    output logic [VERT_W-1:0]   vertmat_data_b,
    output logic                relax_busy,
    output logic                relax_done,
    output logic [IDX_W-1:0]    relax_passes
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NODES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StAddr,
        StCmp,
        StNext,
        StDone
    } state_e;

    state_e              r_state;
    logic [IDX_W-1:0]    r_i;
    logic [IDX_W-1:0]    r_j;
    logic [IDX_W-1:0]    r_pass;
    logic [IDX_W-1:0]    r_passes;
    logic                r_dirty;
    logic                r_wren;
    logic [VERT_W-1:0]   r_data;
    logic                r_busy;
    logic                r_done;

    logic signed [WEIGHT_W:0] w_sum;
    logic signed [WEIGHT_W:0] w_dist_j;
    logic                     w_underflow;
    logic                     w_relax;
    logic [IDX_W-1:0]         w_j_inc;
    logic [IDX_W-1:0]         w_i_inc;
    logic [IDX_W-1:0]         w_pass_inc;
    logic                     w_unused_pred;

    // Pred fields of the read data are not needed for relaxation.
    assign w_unused_pred = ^{vertmat_q_a[VERT_W-1:WEIGHT_W], vertmat_q_b[VERT_W-1:WEIGHT_W]};

    always_comb begin
        // One extra bit keeps the true sum; positive overflow then simply loses the compare.
        w_sum       = {vertmat_q_a[WEIGHT_W-1], vertmat_q_a[WEIGHT_W-1:0]}
                    + {adjmat_q[WEIGHT_W-1], adjmat_q};
        w_dist_j    = {vertmat_q_b[WEIGHT_W-1], vertmat_q_b[WEIGHT_W-1:0]};
        w_underflow = w_sum[WEIGHT_W] & ~w_sum[WEIGHT_W-1];
        w_relax     = (adjmat_q != '0) && !w_underflow && (w_sum < w_dist_j);
        w_j_inc     = r_j + IDX_W'(1);
        w_i_inc     = r_i + IDX_W'(1);
        w_pass_inc  = r_pass + IDX_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= StIdle;
            r_i      <= '0;
            r_j      <= '0;
            r_pass   <= '0;
            r_passes <= '0;
            r_dirty  <= 1'b0;
            r_wren   <= 1'b0;
            r_data   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (relax_start) begin
                        r_state  <= StInit;
                        r_i      <= '0;
                        r_j      <= '0;
                        r_pass   <= '0;
                        r_passes <= '0;
                        r_dirty  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        // First INIT write (vertex 0) is presented in the next cycle.
                        r_wren   <= 1'b1;
                        r_data   <= '0;
                    end
                end
                StInit: begin
                    if (r_j == LAST_IDX) begin
                        r_j     <= '0;
                        r_wren  <= 1'b0;
                        r_state <= StAddr;
                    end else begin
                        r_j    <= w_j_inc;
                        r_wren <= 1'b1;
                        r_data <= {w_j_inc, {WEIGHT_W{1'b0}}};
                    end
                end
                StAddr: begin
                    r_wren  <= 1'b0;
                    r_state <= StCmp;
                end
                StCmp: begin
                    // Write is presented during NEXT, so it lands before the next ADDR read.
                    r_wren <= w_relax;
                    if (w_relax) begin
                        r_data  <= {r_i, w_sum[WEIGHT_W-1:0]};
                        r_dirty <= 1'b1;
                    end
                    r_state <= StNext;
                end
                StNext: begin
                    r_wren <= 1'b0;
                    if (r_j != LAST_IDX) begin
                        r_j     <= w_j_inc;
                        r_state <= StAddr;
                    end else if (r_i != LAST_IDX) begin
                        r_j     <= '0;
                        r_i     <= w_i_inc;
                        r_state <= StAddr;
                    end else begin
                        r_passes <= w_pass_inc;
                        if (!r_dirty || (w_pass_inc == LAST_IDX)) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_pass  <= w_pass_inc;
                            r_i     <= '0;
                            r_j     <= '0;
                            r_dirty <= 1'b0;
                            r_state <= StAddr;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign adjmat_row_addr = r_i;
    assign adjmat_col_addr = r_j;
    assign vertmat_addr_a  = r_i;
    assign vertmat_addr_b  = r_j;
    assign vertmat_wren_b  = r_wren;
    assign vertmat_data_b  = r_data;
    assign relax_busy      = r_busy;
    assign relax_done      = r_done;
    assign relax_passes    = r_passes;

endmodule
